umi_write_tracker: RTL



---
 rtl/umi_write_tracker.sv | 90 +++++++++
 1 files changed

// File: rtl/umi_write_tracker.sv
// UMI write tracker: one-deep request register (1-cycle latency) with write/ack accounting.
// Backpressure: req_ready drops while the register is held, or for a write-ack when acks are full.
module umi_write_tracker #(
  parameter int MAXOUT = 8,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          req_valid,
  input  logic [7:0]    req_cmd,
  output logic          req_ready,
  output logic          out_valid,
  output logic [7:0]    out_cmd,
  input  logic          out_ready,
  input  logic          resp_valid,
  input  logic          resp_ready,
  input  logic [7:0]    resp_cmd,
  input  logic          clear,
  output logic [CW-1:0] write_count,
  output logic [7:0]    ack_pending,
  output logic          full,
  output logic          err
);

  localparam logic [7:0]    MAXOUT_V = 8'(MAXOUT);
  localparam logic [CW-1:0] WC_MAX   = '1;

  logic req_is_write;
  logic req_is_wack;
  logic resp_is_wresp;
  logic accept;
  logic inc;
  logic dec;

  // Writes are request opcodes 1..5; 6 and 7 are atomics, 0 is read.
  assign req_is_write  = req_cmd[0] & (req_cmd[3:1] != 3'b000) & (req_cmd[3:1] <= 3'b101);
  assign req_is_wack   = req_cmd[0] & (req_cmd[3:1] == 3'b011);
  assign resp_is_wresp = ~resp_cmd[0] & (resp_cmd != 8'd0) & (resp_cmd[3:1] == 3'b001);

  // full comes straight from the registered count, so a response only frees a slot next cycle.
  assign full      = (ack_pending == MAXOUT_V);
  assign req_ready = (~out_valid | out_ready) & ~(req_is_wack & full);
  assign accept    = req_valid & req_ready;
  assign inc       = accept & req_is_wack;
  assign dec       = resp_valid & resp_ready & resp_is_wresp;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_cmd   <= 8'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_cmd   <= req_cmd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      write_count <= '0;
    end else if (clear) begin
      write_count <= '0;
    end else if (accept && req_is_write && (write_count != WC_MAX)) begin
      write_count <= write_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ack_pending <= 8'd0;
    end else if (inc && !dec) begin
      ack_pending <= ack_pending + 8'd1;
    end else if (dec && !inc && (ack_pending != 8'd0)) begin
      ack_pending <= ack_pending - 8'd1;
    end
  end

  // A write response with nothing outstanding is a protocol error; sticky until clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (dec && !inc && (ack_pending == 8'd0)) begin
      err <= 1'b1;
    end
  end

endmodule
